bcd_scan_display: RTL
=====================

// Module: bcd_scan_display
// PURPOSE
//  Consumer end of the millisecond counter's 8-bit BCD Count bus (tens:ones, 00..99).
//  Captures the count once per refresh frame and drives a common-anode, time-multiplexed
//  7-segment display (2 active digits of 4).
//  Adds anti-ghost blanking between digits and a frame strobe for the bench/ILA.
//  Sits between the counter top level and the board pins.
// PARAMETERS
//  DIGIT_TICKS  100000  clock cycles per digit slot (1 ms at 100 MHz); legal >= BLANK_TICKS+1
//  BLANK_TICKS  2000    cycles at slot start with all anodes off (anti-ghost); legal >= 1
// PORTS
//  CLK    in   1  system clock; all state on rising edge
//  RST    in   1  asynchronous, active-high reset
//  Count  in   8  BCD input: [7:4] tens, [3:0] ones; may change on any cycle
//  SEG    out  7  segments {g,f,e,d,c,b,a}, active-low
//  DP     out  1  decimal point, active-low; always 1 (off)
//  AN     out  4  anodes, active-low; AN[0]=ones, AN[1]=tens, AN[3:2] always 1
//  Frame  out  1  one-cycle pulse on the cycle Count is captured
// BEHAVIOUR
//  Reset (async): AN=4'b1111, SEG=7'b1111111, DP=1, Frame=0, hold=8'h00,
//    tick=0, state=BLANK0.
//  Tick counter 0..DIGIT_TICKS-1 per slot; wraps to 0 and advances the slot.
//  Outputs are registered.
//  FSM (one slot = DIGIT_TICKS cycles):
//    BLANK0 -> SHOW0 -> BLANK1 -> SHOW1 -> BLANK0.
//  Timing:
//    BLANKx lasts BLANK_TICKS cycles; SHOWx lasts DIGIT_TICKS-BLANK_TICKS cycles.
//    Frame period = 2*DIGIT_TICKS cycles.
//  BLANKx: AN=4'b1111, SEG=7'b1111111.
//  SHOW0: AN=4'b1110, SEG=dec(hold[3:0]).
//  SHOW1: AN=4'b1101, SEG=dec(hold[7:4]) (subject to LZB below).
//  Capture:
//    - hold<=Count on the edge entering BLANK0 (tick wrap from SHOW1), and on the first
//      edge after reset release.
//    - Frame=1 exactly on that edge's following cycle.
//    - Count is never sampled elsewhere, so the display never tears within a frame.
//  dec(): 0..9 use standard patterns (0=7'b1000000, 1=7'b1111001, 5=7'b0010010,
//    7=7'b1111000, 9=7'b0010000).
//  Invalid nibble A..F shows a dash (7'b0111111); the other digit is unaffected.
//  Anode overlap is forbidden: at most one AN bit low in any cycle; all-off in every
//    BLANK cycle.
//  Count changing every cycle is harmless; only the frame-start value is displayed.
//  Reset mid-frame: outputs go to reset values immediately (async).
//    Scan restarts at BLANK0 with a fresh capture.
// CONFIGURATION
//  DISP_LZB_EN defined:
//    - leading-zero blanking: SHOW1 drives AN=4'b1111, SEG=7'b1111111 when hold[7:4]==0.
//    - SHOW1 timing is unchanged, so the frame period is constant.
//    - 07 -> only ones digit lit.
//  DISP_LZB_EN undefined: tens digit always shown; 00..09 display a leading "0".
// TESTING (bench params DIGIT_TICKS=8, BLANK_TICKS=2; frame=16 cycles)
//  1. Reset held, then released with Count=8'h42:
//     - AN=1111 during reset;
//     - ones slot: 2 blank cycles then 6 cycles AN=1110 SEG=7'b0011001;
//     - tens slot: 6 cycles AN=1101 SEG=7'b0100100.
//  2. Count 8'h42->8'h57 mid-SHOW0:
//     - display stays 42 through the frame;
//     - next Frame pulse, then 7 (1111000) / 5 (0010010).
//  3. Count=8'h07:
//     - no LZB: tens SEG=1000000 with AN=1101;
//     - DISP_LZB_EN: AN=1111 for all 8 tens-slot cycles; Frame period still 16.
//  4. Count=8'hA9:
//     - ones SEG=0010000; tens SEG=0111111 (dash).
//  5. Assert RST at SHOW1 tick 4:
//     - AN=1111, SEG=1111111 before next edge;
//     - after release, scan restarts at BLANK0 and hold takes the new Count.
//  6. Run 10 frames with random Count every cycle:
//     - assert never >1 AN low;
//     - assert AN=1111 in every BLANK cycle;
//     - assert Frame pulse every 16 cycles;
//     - assert DP=1 always.

Source files
------------

// File: rtl/bcd_scan_display.sv
// rtl/bcd_scan_display.sv - two-digit multiplexed 7-segment driver for an 8-bit BCD count
// Optional leading-zero blanking of the tens digit: define DISP_LZB_EN.
module bcd_scan_display #(
    parameter int DIGIT_TICKS = 100000,
    parameter int BLANK_TICKS = 2000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] Count,
    output logic [6:0] SEG,
    output logic       DP,
    output logic [3:0] AN,
    output logic       Frame
);

    localparam int TW = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
    localparam logic [TW-1:0] TICK_LAST  = TW'(DIGIT_TICKS - 1);
    localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_TICKS - 1);

    typedef enum logic [1:0] {BLANK0, SHOW0, BLANK1, SHOW1} state_t;

    state_t        state, nxt_state;
    logic [TW-1:0] tick, nxt_tick;
    logic [7:0]    hold, nxt_hold;
    logic          started;
    logic          capture;
    logic [3:0]    an_n;
    logic [6:0]    seg_n;

    function automatic logic [6:0] dec(input logic [3:0] d);
        case (d)
            4'd0:    dec = 7'b1000000;
            4'd1:    dec = 7'b1111001;
            4'd2:    dec = 7'b0100100;
            4'd3:    dec = 7'b0110000;
            4'd4:    dec = 7'b0011001;
            4'd5:    dec = 7'b0010010;
            4'd6:    dec = 7'b0000010;
            4'd7:    dec = 7'b1111000;
            4'd8:    dec = 7'b0000000;
            4'd9:    dec = 7'b0010000;
            default: dec = 7'b0111111;
        endcase
    endfunction

    // The first edge after reset only captures; the scan then begins at BLANK0 tick 0.
    always_comb begin
        capture   = 1'b0;
        nxt_tick  = tick;
        nxt_state = state;
        nxt_hold  = hold;
        if (!started) begin
            capture  = 1'b1;
            nxt_hold = Count;
        end else begin
            nxt_tick = (tick == TICK_LAST) ? '0 : tick + 1'b1;
            case (state)
                BLANK0: if (tick == BLANK_LAST) nxt_state = SHOW0;
                SHOW0:  if (tick == TICK_LAST)  nxt_state = BLANK1;
                BLANK1: if (tick == BLANK_LAST) nxt_state = SHOW1;
                SHOW1: begin
                    if (tick == TICK_LAST) begin
                        nxt_state = BLANK0;
                        capture   = 1'b1;
                        nxt_hold  = Count;
                    end
                end
                default: nxt_state = BLANK0;
            endcase
        end
    end

    // Outputs are decoded from the next state so the registered pins line up with the slot.
    always_comb begin
        an_n  = 4'b1111;
        seg_n = 7'b1111111;
        case (nxt_state)
            SHOW0: begin
                an_n  = 4'b1110;
                seg_n = dec(nxt_hold[3:0]);
            end
            SHOW1: begin
`ifdef DISP_LZB_EN
                if (nxt_hold[7:4] != 4'd0) begin
                    an_n  = 4'b1101;
                    seg_n = dec(nxt_hold[7:4]);
                end
`else
                an_n  = 4'b1101;
                seg_n = dec(nxt_hold[7:4]);
`endif
            end
            default: begin
                an_n  = 4'b1111;
                seg_n = 7'b1111111;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= BLANK0;
            tick    <= '0;
            hold    <= 8'h00;
            started <= 1'b0;
            Frame   <= 1'b0;
            AN      <= 4'b1111;
            SEG     <= 7'b1111111;
        end else begin
            state   <= nxt_state;
            tick    <= nxt_tick;
            hold    <= nxt_hold;
            started <= 1'b1;
            Frame   <= capture;
            AN      <= an_n;
            SEG     <= seg_n;
        end
    end

    assign DP = 1'b1;

endmodule
